// File: rtl/minmax_frame_pkg.sv
// minmax_frame_pkg
//   Shared definitions for the minmax_frame block: the 2-bit FSM state
//   encoding and the default sample width and frame length.
package minmax_frame_pkg;

  localparam int DEF_WIDTH     = 16;
  localparam int DEF_FRAME_LEN = 8;
  localparam int DEF_IDX_W     = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/minmax_frame_compare_nbit.sv
// compare_nbit
//   Unsigned magnitude comparator of two WIDTH-bit operands.
//   Ports:
//     a, b  : operands (unsigned)
//     lt    : a <  b
//     eq    : a == b
//     gt    : a >  b
//   Purely combinational; exactly one of lt/eq/gt is high for known inputs.
module compare_nbit #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             lt,
  output logic             eq,
  output logic             gt
);

  assign lt = (a <  b);
  assign eq = (a == b);
  assign gt = (a >  b);

endmodule

// File: rtl/minmax_frame.sv
// minmax_frame
//   Streaming unsigned min/max tracker. Collects FRAME_LEN samples from a
//   valid/ready input, tracks the running minimum and maximum together with
//   the index of their first occurrence, then presents the frame result on a
//   valid/ready output before starting the next frame.
//   Ports:
//     clk, rst     : clock, asynchronous active-high reset
//     in_valid     : sample present
//     in_ready     : block can accept a sample (low only while a result waits)
//     in_data      : unsigned sample
//     out_valid    : frame result present
//     out_ready    : consumer accepts the result
//     out_min/max  : smallest / largest sample of the frame
//     out_min_idx  : 0-based index of the first occurrence of the minimum
//     out_max_idx  : 0-based index of the first occurrence of the maximum
module minmax_frame
  import minmax_frame_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int FRAME_LEN = DEF_FRAME_LEN,
  parameter int IDX_W     = DEF_IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_min,
  output logic [WIDTH-1:0] out_max,
  output logic [IDX_W-1:0] out_min_idx,
  output logic [IDX_W-1:0] out_max_idx
);

  // Index of the last sample in a frame; reaching it closes the frame.
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  state_t           state_reg;
  logic [IDX_W-1:0] count_reg;
  logic [WIDTH-1:0] min_reg,     min_next;
  logic [WIDTH-1:0] max_reg,     max_next;
  logic [IDX_W-1:0] min_idx_reg, min_idx_next;
  logic [IDX_W-1:0] max_idx_reg, max_idx_next;

  logic in_xfer;
  logic min_lt;
  logic max_gt;
  logic unused_min_eq, unused_min_gt;
  logic unused_max_lt, unused_max_eq;

  assign in_ready = (state_reg != ST_DONE);
  assign in_xfer  = in_valid && in_ready;

  compare_nbit #(.WIDTH(WIDTH)) u_cmp_min (
    .a  (in_data),
    .b  (min_reg),
    .lt (min_lt),
    .eq (unused_min_eq),
    .gt (unused_min_gt)
  );

  compare_nbit #(.WIDTH(WIDTH)) u_cmp_max (
    .a  (in_data),
    .b  (max_reg),
    .lt (unused_max_lt),
    .eq (unused_max_eq),
    .gt (max_gt)
  );

  // Candidate running values for the sample currently on in_data. They are
  // only loaded on an input transfer, so X on in_data during a bubble never
  // reaches the registers. Strict lt/gt keeps the earliest index on ties.
  always_comb begin
    min_next     = min_reg;
    max_next     = max_reg;
    min_idx_next = min_idx_reg;
    max_idx_next = max_idx_reg;
    if (state_reg == ST_IDLE) begin
      min_next     = in_data;
      max_next     = in_data;
      min_idx_next = '0;
      max_idx_next = '0;
    end else begin
      if (min_lt) begin
        min_next     = in_data;
        min_idx_next = count_reg;
      end
      if (max_gt) begin
        max_next     = in_data;
        max_idx_next = count_reg;
      end
    end
  end

  // FSM plus all state and result registers. The out_* registers are loaded
  // only when a frame closes, so they stay put after the handshake while the
  // next frame accumulates in the running registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      count_reg   <= '0;
      min_reg     <= '0;
      max_reg     <= '0;
      min_idx_reg <= '0;
      max_idx_reg <= '0;
      out_valid   <= 1'b0;
      out_min     <= '0;
      out_max     <= '0;
      out_min_idx <= '0;
      out_max_idx <= '0;
    end else begin
      case (state_reg)
        ST_IDLE, ST_ACCUM: begin
          if (in_xfer) begin
            min_reg     <= min_next;
            max_reg     <= max_next;
            min_idx_reg <= min_idx_next;
            max_idx_reg <= max_idx_next;
            // In IDLE count_reg is 0, so the same test covers FRAME_LEN==1.
            if (count_reg == LAST_IDX) begin
              state_reg   <= ST_DONE;
              out_valid   <= 1'b1;
              out_min     <= min_next;
              out_max     <= max_next;
              out_min_idx <= min_idx_next;
              out_max_idx <= max_idx_next;
            end else begin
              state_reg <= ST_ACCUM;
              count_reg <= count_reg + 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_reg <= ST_IDLE;
            out_valid <= 1'b0;
            count_reg <= '0;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          out_valid <= 1'b0;
          count_reg <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_minmax_frame.sv
// tb_minmax_frame
//   Directed bench for minmax_frame (WIDTH=16, FRAME_LEN=8, IDX_W=3).
//   Inputs change on the falling edge / 1 time unit after the rising edge;
//   outputs are sampled 1 time unit after the rising edge.
module tb_minmax_frame;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_min;
  logic [15:0] out_max;
  logic [2:0]  out_min_idx;
  logic [2:0]  out_max_idx;

  int passed;
  int total;

  minmax_frame #(.WIDTH(16), .FRAME_LEN(8), .IDX_W(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_min     (out_min),
    .out_max     (out_max),
    .out_min_idx (out_min_idx),
    .out_max_idx (out_max_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one sample for exactly one rising edge.
  task automatic push(input logic [15:0] d);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 'x;
  endtask

  // One idle edge with in_valid low and in_data undefined.
  task automatic bubble();
    @(posedge clk);
    #1;
  endtask

  // Accept the pending result with a one-cycle out_ready pulse.
  task automatic consume();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (out_valid !== 1'b0)  $display("FAIL reset_out_valid got %0b exp 0", out_valid); else passed++;
    total++; if (in_ready !== 1'b1)   $display("FAIL reset_in_ready got %0b exp 1", in_ready); else passed++;
    total++; if (out_min !== 16'h0)   $display("FAIL reset_out_min got %0h exp 0", out_min); else passed++;
    total++; if (out_max !== 16'h0)   $display("FAIL reset_out_max got %0h exp 0", out_max); else passed++;
    total++; if (out_min_idx !== 3'd0 || out_max_idx !== 3'd0)
      $display("FAIL reset_idx got %0d/%0d exp 0/0", out_min_idx, out_max_idx); else passed++;
    @(negedge clk);
    rst = 1'b0;
    $display("reset: out_valid=%0b in_ready=%0b", out_valid, in_ready);
  endtask

  task automatic test_basic();
    logic [15:0] s [8] = '{16'd5, 16'd4, 16'd6, 16'd6, 16'd3, 16'd9, 16'd0, 16'd9};
    for (int i = 0; i < 7; i++) push(s[i]);
    total++; if (out_valid !== 1'b0) $display("FAIL basic_valid_early got %0b exp 0", out_valid); else passed++;
    push(s[7]);
    total++; if (out_valid !== 1'b1) $display("FAIL basic_latency got %0b exp 1", out_valid); else passed++;
    total++; if (in_ready !== 1'b0)  $display("FAIL basic_in_ready_done got %0b exp 0", in_ready); else passed++;
    total++; if (out_min !== 16'd0 || out_min_idx !== 3'd6)
      $display("FAIL basic_min got %0d@%0d exp 0@6", out_min, out_min_idx); else passed++;
    total++; if (out_max !== 16'd9 || out_max_idx !== 3'd5)
      $display("FAIL basic_max got %0d@%0d exp 9@5", out_max, out_max_idx); else passed++;
    $display("basic frame: min=%0d@%0d max=%0d@%0d", out_min, out_min_idx, out_max, out_max_idx);
    consume();
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL basic_after_xfer got valid=%0b ready=%0b exp 0/1", out_valid, in_ready); else passed++;
    total++; if (out_max !== 16'd9 || out_max_idx !== 3'd5)
      $display("FAIL basic_retain got %0d@%0d exp 9@5", out_max, out_max_idx); else passed++;
  endtask

  task automatic test_ties();
    for (int i = 0; i < 8; i++) push(16'h0006);
    total++; if (out_valid !== 1'b1) $display("FAIL ties_valid got %0b exp 1", out_valid); else passed++;
    total++; if (out_min !== 16'h6 || out_min_idx !== 3'd0)
      $display("FAIL ties_min got %0h@%0d exp 6@0", out_min, out_min_idx); else passed++;
    total++; if (out_max !== 16'h6 || out_max_idx !== 3'd0)
      $display("FAIL ties_max got %0h@%0d exp 6@0", out_max, out_max_idx); else passed++;
    $display("ties frame: min=%0h@%0d max=%0h@%0d", out_min, out_min_idx, out_max, out_max_idx);
    consume();
  endtask

  task automatic test_extremes();
    logic [15:0] s [8] = '{16'hFFFF, 16'h0000, 16'h8000, 16'h7FFF,
                           16'h0001, 16'hFFFE, 16'h8001, 16'h0000};
    for (int i = 0; i < 8; i++) push(s[i]);
    total++; if (out_valid !== 1'b1) $display("FAIL extremes_valid got %0b exp 1", out_valid); else passed++;
    total++; if (out_max !== 16'hFFFF || out_max_idx !== 3'd0)
      $display("FAIL extremes_max got %0h@%0d exp ffff@0", out_max, out_max_idx); else passed++;
    total++; if (out_min !== 16'h0000 || out_min_idx !== 3'd1)
      $display("FAIL extremes_min got %0h@%0d exp 0@1", out_min, out_min_idx); else passed++;
    $display("extremes frame: min=%0h@%0d max=%0h@%0d", out_min, out_min_idx, out_max, out_max_idx);
    consume();
  endtask

  task automatic test_backpressure();
    logic [15:0] s [8] = '{16'd3, 16'd1, 16'd4, 16'd1, 16'd5, 16'd9, 16'd2, 16'd6};
    logic [15:0] t [7] = '{16'd50, 16'd60, 16'd70, 16'd80, 16'd90, 16'd100, 16'd110};
    int bad_hold;
    for (int i = 0; i < 8; i++) push(s[i]);
    // Offer a new sample that would become the new minimum if wrongly accepted.
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 16'd0;
    bad_hold = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_min !== 16'd1 || out_min_idx !== 3'd1 ||
          out_max !== 16'd9 || out_max_idx !== 3'd5) bad_hold++;
    end
    total++; if (bad_hold != 0)
      $display("FAIL bp_hold got %0d bad cycles (last valid=%0b ready=%0b min=%0d@%0d max=%0d@%0d) exp 0",
               bad_hold, out_valid, in_ready, out_min, out_min_idx, out_max, out_max_idx); else passed++;
    $display("backpressure frame: min=%0d@%0d max=%0d@%0d", out_min, out_min_idx, out_max, out_max_idx);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL bp_release got valid=%0b ready=%0b exp 0/1", out_valid, in_ready); else passed++;
    // The held sample 0 is taken on the following edge as index 0.
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 'x;
    for (int i = 0; i < 7; i++) push(t[i]);
    total++; if (out_valid !== 1'b1) $display("FAIL bp_next_valid got %0b exp 1", out_valid); else passed++;
    total++; if (out_min !== 16'd0 || out_min_idx !== 3'd0)
      $display("FAIL bp_next_min got %0d@%0d exp 0@0", out_min, out_min_idx); else passed++;
    total++; if (out_max !== 16'd110 || out_max_idx !== 3'd7)
      $display("FAIL bp_next_max got %0d@%0d exp 110@7", out_max, out_max_idx); else passed++;
    $display("post-backpressure frame: min=%0d@%0d max=%0d@%0d", out_min, out_min_idx, out_max, out_max_idx);
    consume();
  endtask

  task automatic test_bubbles();
    logic [15:0] s [8] = '{16'd5, 16'd4, 16'd6, 16'd6, 16'd3, 16'd9, 16'd0, 16'd9};
    for (int i = 0; i < 8; i++) begin
      push(s[i]);
      if (i < 7) bubble();
      if (i == 6) begin
        total++; if (out_valid !== 1'b0) $display("FAIL bubbles_valid_early got %0b exp 0", out_valid); else passed++;
      end
    end
    total++; if (out_valid !== 1'b1) $display("FAIL bubbles_valid got %0b exp 1", out_valid); else passed++;
    total++; if (out_min !== 16'd0 || out_min_idx !== 3'd6)
      $display("FAIL bubbles_min got %0d@%0d exp 0@6", out_min, out_min_idx); else passed++;
    total++; if (out_max !== 16'd9 || out_max_idx !== 3'd5)
      $display("FAIL bubbles_max got %0d@%0d exp 9@5", out_max, out_max_idx); else passed++;
    $display("bubbles frame: min=%0d@%0d max=%0d@%0d", out_min, out_min_idx, out_max, out_max_idx);
    consume();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) push(16'(20 + i));
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL rstmid_ctrl got valid=%0b ready=%0b exp 0/1", out_valid, in_ready); else passed++;
    total++; if (out_min !== 16'd0 || out_max !== 16'd0 || out_min_idx !== 3'd0 || out_max_idx !== 3'd0)
      $display("FAIL rstmid_outs got %0d@%0d %0d@%0d exp all 0", out_min, out_min_idx, out_max, out_max_idx); else passed++;
    @(negedge clk);
    rst = 1'b0;
    $display("reset mid-frame: out_valid=%0b in_ready=%0b", out_valid, in_ready);
    for (int i = 1; i <= 7; i++) push(16'(i));
    total++; if (out_valid !== 1'b0) $display("FAIL rstmid_no_early got %0b exp 0", out_valid); else passed++;
    push(16'd8);
    total++; if (out_valid !== 1'b1) $display("FAIL rstmid_valid got %0b exp 1", out_valid); else passed++;
    total++; if (out_min !== 16'd1 || out_min_idx !== 3'd0)
      $display("FAIL rstmid_min got %0d@%0d exp 1@0", out_min, out_min_idx); else passed++;
    total++; if (out_max !== 16'd8 || out_max_idx !== 3'd7)
      $display("FAIL rstmid_max got %0d@%0d exp 8@7", out_max, out_max_idx); else passed++;
    $display("post-reset frame: min=%0d@%0d max=%0d@%0d", out_min, out_min_idx, out_max, out_max_idx);
    consume();
  endtask

  initial begin
    passed = 0;
    total  = 0;
    test_reset();
    test_basic();
    test_ties();
    test_extremes();
    test_backpressure();
    test_bubbles();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
